// File: rtl/inst_rom_loader.sv
// Instruction ROM for the core's fetch port, filled from a byte-stream load port.
// The core is held in reset while a load is in progress.
module inst_rom_loader #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_ce_i,
  input  logic [31:0]           rom_addr_i,
  output logic [31:0]           rom_data_o,
  input  logic                  load_start_i,
  input  logic [31:0]           load_words_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  byte_ready_o,
  output logic                  cpu_rst_o,
  output logic                  load_done_o,
  output logic [DEPTH_LOG2:0]   word_cnt_o
);

  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 32'(1) << DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_d;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   len_clamp;
  logic [CNT_W-1:0]   word_cnt_inc;
  logic [1:0]         byte_cnt;
  logic [23:0]        asm_q;
  logic [31:0]        mem [DEPTH];
  logic               start_ok;
  logic               byte_xfer;
  logic               word_wr;
  logic               load_last;
  logic               cpu_rst_d;
  logic               byte_ready_d;
  logic               load_done_d;
  logic               unused_addr_lsb;

  // Requested length clamped to the array depth so the write index never wraps
  assign len_clamp    = (load_words_i > DEPTH) ? CNT_W'(DEPTH) : CNT_W'(load_words_i);
  assign start_ok     = load_start_i && (state != ST_LOAD);
  assign byte_xfer    = byte_valid_i && byte_ready_o;
  assign word_wr      = byte_xfer && (byte_cnt == 2'd3);
  assign word_cnt_inc = word_cnt_o + CNT_W'(1);
  assign load_last    = word_wr && (word_cnt_inc == len_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE, ST_RUN: begin
        if (load_start_i) begin
          state_d = (len_clamp == '0) ? ST_RUN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (load_last) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state, so outputs change on the same edge as the state
  always_comb begin
    cpu_rst_d    = 1'b1;
    byte_ready_d = 1'b0;
    load_done_d  = 1'b0;
    if (state_d == ST_RUN) begin
      cpu_rst_d = 1'b0;
    end
    if (state_d == ST_LOAD) begin
      byte_ready_d = 1'b1;
    end
    if ((start_ok && (len_clamp == '0)) || load_last) begin
      load_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rst_o    <= 1'b1;
      byte_ready_o <= 1'b0;
      load_done_o  <= 1'b0;
    end else begin
      cpu_rst_o    <= cpu_rst_d;
      byte_ready_o <= byte_ready_d;
      load_done_o  <= load_done_d;
    end
  end

  // Byte assembly and word counting
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      word_cnt_o <= '0;
      byte_cnt   <= 2'd0;
      asm_q      <= 24'd0;
    end else if (start_ok) begin
      len_q      <= len_clamp;
      word_cnt_o <= '0;
      byte_cnt   <= 2'd0;
      asm_q      <= 24'd0;
    end else if (byte_xfer) begin
      asm_q    <= {asm_q[15:0], byte_i};
      byte_cnt <= byte_cnt + 2'd1;
      if (byte_cnt == 2'd3) begin
        word_cnt_o <= word_cnt_inc;
      end
    end
  end

  // Word array has no reset; contents survive rst
  always_ff @(posedge clk) begin
    if (!rst && word_wr) begin
      mem[word_cnt_o[DEPTH_LOG2-1:0]] <= {asm_q, byte_i};
    end
  end

  // Zero-latency fetch, gated by RUN, enable and address range
  always_comb begin
    rom_data_o = 32'd0;
    if ((state == ST_RUN) && rom_ce_i && ((rom_addr_i >> (DEPTH_LOG2 + 2)) == 32'd0)) begin
      rom_data_o = mem[rom_addr_i[DEPTH_LOG2+1:2]];
    end
  end

  assign unused_addr_lsb = ^rom_addr_i[1:0];

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: fetch vector table plus hand-written
// load, reload, reset and clamp sequences.
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        load_start;
  logic [31:0] load_words;
  logic        byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready;
  logic        cpu_rst;
  logic        load_done;
  logic [10:0] word_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic [31:0] exp;
  } fetch_vec_t;

  fetch_vec_t fv [9];
  logic [7:0] t1_b  [8];
  logic [7:0] thr_b [4];
  logic [7:0] rl_b  [8];
  logic [7:0] one_b [4];

  inst_rom_loader #(.DEPTH_LOG2(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_i     (rom_ce),
    .rom_addr_i   (rom_addr),
    .rom_data_o   (rom_data),
    .load_start_i (load_start),
    .load_words_i (load_words),
    .byte_valid_i (byte_valid),
    .byte_i       (byte_in),
    .byte_ready_o (byte_ready),
    .cpu_rst_o    (cpu_rst),
    .load_done_o  (load_done),
    .word_cnt_o   (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fetch(input string name, input logic [31:0] addr, input logic [31:0] exp);
    rom_ce   = 1'b1;
    rom_addr = addr;
    #1;
    check(name, rom_data, exp);
  endtask

  // Present one byte and wait (bounded) until it is taken; valid stays high
  task automatic send_byte(input logic [7:0] b);
    int budget = 0;
    byte_valid = 1'b1;
    byte_in    = b;
    while (!byte_ready && budget < 20) begin
      tick();
      budget++;
    end
    if (!byte_ready) check("send_byte_timeout", 32'(byte_ready), 32'd1);
    tick();
  endtask

  task automatic start_load(input logic [31:0] n);
    load_words = n;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int xfers;
    int done_cnt;
    int acc;
    logic a;

    t1_b  = '{8'h34, 8'h02, 8'h00, 8'h01, 8'h24, 8'h03, 8'h00, 8'h02};
    thr_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    rl_b  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    one_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    fv[0] = '{1'b1, 32'h0000_0000, 32'h3402_0001};
    fv[1] = '{1'b1, 32'h0000_0004, 32'h2403_0002};
    fv[2] = '{1'b1, 32'h0000_0005, 32'h2403_0002};
    fv[3] = '{1'b1, 32'h0000_0007, 32'h2403_0002};
    fv[4] = '{1'b1, 32'h0000_0002, 32'h3402_0001};
    fv[5] = '{1'b1, 32'h0000_1000, 32'h0000_0000};
    fv[6] = '{1'b1, 32'h8000_0004, 32'h0000_0000};
    fv[7] = '{1'b0, 32'h0000_0000, 32'h0000_0000};
    fv[8] = '{1'b0, 32'h0000_0004, 32'h0000_0000};

    rst = 1'b1; rom_ce = 1'b1; rom_addr = 32'd0;
    load_start = 1'b0; load_words = 32'd0; byte_valid = 1'b0; byte_in = 8'd0;
    tick();
    tick();
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_rom_data", rom_data, 32'd0);
    rst = 1'b0;
    tick();

    // Two-word back-to-back load
    start_load(32'd2);
    check("t1_ready_in_load", 32'(byte_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("t1_cpu_rst_before_last", 32'(cpu_rst), 32'd1);
      send_byte(t1_b[i]);
    end
    byte_valid = 1'b0;
    check("t1_cpu_rst_fall", 32'(cpu_rst), 32'd0);
    check("t1_done_pulse", 32'(load_done), 32'd1);
    check("t1_word_cnt", 32'(word_cnt), 32'd2);
    check("t1_ready_drop", 32'(byte_ready), 32'd0);
    tick();
    check("t1_done_one_cycle", 32'(load_done), 32'd0);

    for (int i = 0; i < 9; i++) begin
      rom_ce   = fv[i].ce;
      rom_addr = fv[i].addr;
      #1;
      check($sformatf("fetch_vec%0d", i), rom_data, fv[i].exp);
    end

    // Bytes offered in RUN are ignored
    byte_valid = 1'b1; byte_in = 8'hFF;
    check("run_not_ready", 32'(byte_ready), 32'd0);
    tick();
    tick();
    byte_valid = 1'b0;
    check("run_word_cnt_kept", 32'(word_cnt), 32'd2);
    check("run_cpu_rst_low", 32'(cpu_rst), 32'd0);

    // Throttled one-word load
    start_load(32'd1);
    fetch("fetch_during_load", 32'd0, 32'd0);
    xfers = 0; done_cnt = 0;
    for (int k = 0; k < 24; k++) begin
      byte_valid = (k % 2 == 0);
      byte_in    = (xfers < 4) ? thr_b[xfers] : 8'hEE;
      a = byte_valid && byte_ready;
      tick();
      if (load_done) done_cnt++;
      if (a) begin
        xfers++;
        if (xfers == 4) begin
          check("thr_done_after_last", 32'(load_done), 32'd1);
          check("thr_cpu_rst_after_last", 32'(cpu_rst), 32'd0);
        end
      end
    end
    byte_valid = 1'b0;
    check("thr_xfers", 32'(xfers), 32'd4);
    check("thr_done_count", 32'(done_cnt), 32'd1);
    check("thr_word_cnt", 32'(word_cnt), 32'd1);
    fetch("thr_mem0", 32'd0, 32'hAABB_CCDD);
    fetch("thr_mem1_kept", 32'd4, 32'h2403_0002);

    // Zero-length load completes immediately
    byte_valid = 1'b1; byte_in = 8'h55;
    start_load(32'd0);
    byte_valid = 1'b0;
    check("len0_done", 32'(load_done), 32'd1);
    check("len0_cpu_rst", 32'(cpu_rst), 32'd0);
    check("len0_ready", 32'(byte_ready), 32'd0);
    check("len0_word_cnt", 32'(word_cnt), 32'd0);
    fetch("len0_mem0_kept", 32'd0, 32'hAABB_CCDD);
    tick();
    check("len0_done_one_cycle", 32'(load_done), 32'd0);

    // Start with valid high in RUN; start pulse in LOAD must be ignored
    load_words = 32'd2; load_start = 1'b1; byte_valid = 1'b1; byte_in = rl_b[0];
    tick();
    load_start = 1'b0;
    check("rl_start_clears_cnt", 32'(word_cnt), 32'd0);
    check("rl_ready", 32'(byte_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        load_start = 1'b1;
        load_words = 32'd5;
      end
      send_byte(rl_b[i]);
      load_start = 1'b0;
      if (i == 3) check("rl_cnt_after_word0", 32'(word_cnt), 32'd1);
      if (i == 4) check("rl_start_in_load_cnt", 32'(word_cnt), 32'd1);
    end
    byte_valid = 1'b0;
    check("rl_done", 32'(load_done), 32'd1);
    check("rl_word_cnt", 32'(word_cnt), 32'd2);
    fetch("rl_mem0", 32'd0, 32'h0102_0304);
    fetch("rl_mem1", 32'd4, 32'h0506_0708);

    // One-word reload keeps word 1
    start_load(32'd1);
    check("rl1_cpu_rst_high", 32'(cpu_rst), 32'd1);
    for (int i = 0; i < 4; i++) send_byte(one_b[i]);
    byte_valid = 1'b0;
    check("rl1_word_cnt", 32'(word_cnt), 32'd1);
    check("rl1_cpu_rst_low", 32'(cpu_rst), 32'd0);
    fetch("rl1_mem0", 32'd0, 32'h1122_3344);
    fetch("rl1_mem1_kept", 32'd4, 32'h0506_0708);

    // Reset in the middle of a word
    start_load(32'd3);
    send_byte(8'hDE);
    send_byte(8'hAD);
    byte_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("mid_rst_ready", 32'(byte_ready), 32'd0);
    check("mid_rst_word_cnt", 32'(word_cnt), 32'd0);
    fetch("mid_rst_fetch_idle", 32'd0, 32'd0);
    byte_valid = 1'b1; byte_in = 8'h77;
    tick();
    byte_valid = 1'b0;
    check("idle_not_ready", 32'(byte_ready), 32'd0);
    check("idle_word_cnt", 32'(word_cnt), 32'd0);
    start_load(32'd0);
    check("mid_rst_run_done", 32'(load_done), 32'd1);
    fetch("mid_rst_mem0_kept", 32'd0, 32'h1122_3344);

    // Oversized length clamps to 1024 words
    start_load(32'd2000);
    acc = 0; done_cnt = 0;
    for (int k = 0; k < 4200; k++) begin
      byte_valid = 1'b1;
      byte_in    = 8'(acc);
      a = byte_ready;
      tick();
      if (a) acc++;
      if (load_done) done_cnt++;
      if (!byte_ready) break;
    end
    check("clamp_bytes", 32'(acc), 32'd4096);
    check("clamp_done_count", 32'(done_cnt), 32'd1);
    check("clamp_word_cnt", 32'(word_cnt), 32'd1024);
    check("clamp_ready_low", 32'(byte_ready), 32'd0);
    check("clamp_cpu_rst_low", 32'(cpu_rst), 32'd0);
    tick();
    tick();
    byte_valid = 1'b0;
    check("clamp_word_cnt_hold", 32'(word_cnt), 32'd1024);
    fetch("clamp_mem0", 32'd0, 32'h0001_0203);
    fetch("clamp_mem1023", 32'h0000_0FFC, 32'hFCFD_FEFF);
    fetch("clamp_out_of_range", 32'h0000_1000, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
